// File: rtl/rv_pkg.sv
// rv_pkg: shared RV32I opcodes, instruction format enum, NOP word and opcode-to-format lookup
package rv_pkg;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [31:0] NOP = 32'h0000_0013;
  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_J, FMT_U, FMT_BAD} fmt_e;
  function automatic fmt_e fmt_of(input logic [6:0] op);
    return op == OP_R ? FMT_R :
           (op == OP_IMM || op == OP_LOAD || op == OP_JALR) ? FMT_I :
           op == OP_STORE ? FMT_S :
           op == OP_BRANCH ? FMT_B :
           op == OP_JAL ? FMT_J :
           (op == OP_LUI || op == OP_AUIPC) ? FMT_U : FMT_BAD;
  endfunction
endpackage

// File: rtl/imm_pack.sv
// imm_pack: combinational RV32I packer; opcode/rd/rs1/rs2/funct3/funct7/imm in, instr/err out (err gives NOP)
module imm_pack
  import rv_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] instr,
  output logic        err
);
  fmt_e fmt;
  logic s12, s13, s21;
  logic [31:0] raw;
  always_comb begin
    fmt = fmt_of(opcode);
    s12 = &imm[31:11] || ~|imm[31:11];
    s13 = (&imm[31:12] || ~|imm[31:12]) && !imm[0];
    s21 = (&imm[31:20] || ~|imm[31:20]) && !imm[0];
    err = fmt == FMT_BAD || ((fmt == FMT_I || fmt == FMT_S) && !s12) ||
          (fmt == FMT_B && !s13) || (fmt == FMT_J && !s21);
    case (fmt)
      FMT_R:   raw = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I:   raw = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_S:   raw = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_B:   raw = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      FMT_J:   raw = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      FMT_U:   raw = {imm[31:12], rd, opcode};
      default: raw = NOP;
    endcase
    instr = err ? NOP : raw;
  end
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: registered RV32I encoder; in_* fields via valid/ready, out_instr/out_addr/out_err via valid/ready, addr_clr restarts address, err_count saturates
module instr_encoder
  import rv_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  input  logic              addr_clr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic [7:0]        err_count
);
  typedef enum logic {EMPTY, FULL} st_e;
  st_e st;
  logic [ADDR_W-1:0] next_addr, cur_addr;
  logic [31:0] p_instr;
  logic p_err, acc;
  imm_pack u_pack (
    .opcode(in_opcode),
    .rd(in_rd),
    .rs1(in_rs1),
    .rs2(in_rs2),
    .funct3(in_funct3),
    .funct7(in_funct7),
    .imm(in_imm),
    .instr(p_instr),
    .err(p_err)
  );
  assign in_ready  = st == EMPTY || out_ready;
  assign acc       = in_valid && in_ready;
  assign cur_addr  = addr_clr ? BASE_ADDR : next_addr;
  assign out_valid = st == FULL;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= EMPTY;
      out_instr <= '0;
      out_addr  <= BASE_ADDR;
      out_err   <= 1'b0;
      err_count <= '0;
      next_addr <= BASE_ADDR;
    end else if (acc) begin
      st        <= FULL;
      out_instr <= p_instr;
      out_err   <= p_err;
      out_addr  <= cur_addr;
      next_addr <= cur_addr + ADDR_W'(4);
      err_count <= err_count + {7'b0, p_err && err_count != 8'hff};
    end else begin
      st        <= out_ready ? EMPTY : st;
      next_addr <= cur_addr;
    end
  end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: randomized + directed bench for instr_encoder against a behavioural model
module tb_instr_encoder;
  localparam logic [31:0] BASE = 32'h0;
  logic clk = 0, rst_n = 0;
  logic in_valid = 0, in_ready, addr_clr = 0, out_valid, out_ready = 1, out_err;
  logic [6:0] in_opcode = 0, in_funct7 = 0;
  logic [4:0] in_rd = 0, in_rs1 = 0, in_rs2 = 0;
  logic [2:0] in_funct3 = 0;
  logic [31:0] in_imm = 0, out_instr, out_addr;
  logic [7:0] err_count;
  int n_cmp = 0, n_bad = 0;
  bit m_full, m_err;
  logic [31:0] m_instr, m_addr, m_next;
  int m_cnt;
  logic [6:0] ops[10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011,
                          7'b1100011, 7'b1101111, 7'b0110111, 7'b0010111, 7'b0};
  instr_encoder #(.ADDR_W(32), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm), .addr_clr(addr_clr),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .out_err(out_err), .err_count(err_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic void enc(input logic [6:0] op, input logic [4:0] rd, rs1, rs2,
                              input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] u,
                              output logic [31:0] w, output bit e);
    int v = $signed(u);
    e = 0;
    case (op)
      7'b0110011: w = {f7, rs2, rs1, f3, rd, op};
      7'b0010011, 7'b0000011, 7'b1100111: begin
        e = v < -2048 || v > 2047;
        w = {u[11:0], rs1, f3, rd, op};
      end
      7'b0100011: begin
        e = v < -2048 || v > 2047;
        w = {u[11:5], rs2, rs1, f3, u[4:0], op};
      end
      7'b1100011: begin
        e = v < -4096 || v > 4094 || v % 2 != 0;
        w = {u[12], u[10:5], rs2, rs1, f3, u[4:1], u[11], op};
      end
      7'b1101111: begin
        e = v < -1048576 || v > 1048574 || v % 2 != 0;
        w = {u[20], u[10:1], u[11], u[19:12], rd, op};
      end
      7'b0110111, 7'b0010111: w = {u[31:12], rd, op};
      default: begin e = 1; w = 0; end
    endcase
    if (e) w = 32'h0000_0013;
  endfunction
  task automatic model_reset;
    m_full = 0; m_err = 0; m_instr = 0; m_addr = BASE; m_next = BASE; m_cnt = 0;
  endtask
  task automatic cyc;
    bit rdy, acc, e;
    logic [31:0] w, a;
    #1;
    rdy = !m_full || out_ready;
    chk("in_ready", {31'b0, in_ready}, {31'b0, rdy});
    acc = in_valid && rdy;
    enc(in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, w, e);
    @(posedge clk);
    if (acc) begin
      a = addr_clr ? BASE : m_next;
      m_addr = a; m_next = a + 4; m_instr = w; m_err = e; m_full = 1;
      if (e && m_cnt < 255) m_cnt++;
    end else begin
      if (out_ready) m_full = 0;
      if (addr_clr) m_next = BASE;
    end
    @(negedge clk);
    chk("out_valid", {31'b0, out_valid}, {31'b0, m_full});
    chk("err_count", {24'b0, err_count}, m_cnt);
    if (m_full) begin
      chk("out_instr", out_instr, m_instr);
      chk("out_addr", out_addr, m_addr);
      chk("out_err", {31'b0, out_err}, {31'b0, m_err});
    end
  endtask
  task automatic drive(input bit v, r, c, input logic [6:0] op, input logic [4:0] rd, rs1, rs2,
                       input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm);
    in_valid = v; out_ready = r; addr_clr = c; in_opcode = op; in_rd = rd; in_rs1 = rs1;
    in_rs2 = rs2; in_funct3 = f3; in_funct7 = f7; in_imm = imm;
    cyc();
  endtask
  task automatic send(input logic [6:0] op, input logic [4:0] rd, rs1, rs2,
                      input logic [2:0] f3, input logic [31:0] imm);
    drive(1, 1, 0, op, rd, rs1, rs2, f3, 7'h0, imm);
  endtask
  task automatic do_reset;
    in_valid = 0; addr_clr = 0; out_ready = 1; rst_n = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_out_addr", out_addr, BASE);
    chk("rst_out_err", {31'b0, out_err}, 0);
    chk("rst_err_count", {24'b0, err_count}, 0);
    rst_n = 1;
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    int sv;
    logic [31:0] held;
    do_reset();
    send(7'b0010011, 1, 0, 0, 0, 5);
    chk("addi", out_instr, 32'h00500093);
    chk("addi_addr", out_addr, BASE);
    do_reset();
    send(7'b0100011, 0, 1, 2, 2, 8);
    chk("sw", out_instr, 32'h0020A423);
    send(7'b1100011, 0, 0, 0, 0, -4);
    chk("beq", out_instr, 32'hFE000EE3);
    chk("beq_addr", out_addr, BASE + 4);
    send(7'b1101111, 1, 0, 0, 0, 2048);
    chk("jal", out_instr, 32'h001000EF);
    send(7'b1100111, 0, 1, 0, 0, -1);
    chk("jalr", out_instr, 32'hFFF08067);
    do_reset();
    send(7'b0010011, 1, 0, 0, 0, 2048);
    chk("addi_range_err", {31'b0, out_err}, 1);
    send(7'b1100011, 0, 0, 0, 0, 3);
    chk("br_odd_instr", out_instr, 32'h0000_0013);
    chk("two_errs", {24'b0, err_count}, 2);
    held = out_addr;
    repeat (3) drive(1, 0, 0, 7'b0010011, 3, 4, 0, 0, 7'h0, 100);
    drive(1, 1, 0, 7'b0010011, 3, 4, 0, 0, 7'h0, 100);
    chk("queued_addr", out_addr, held + 4);
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    do_reset();
    repeat (4) send(7'b0110111, 5, 0, 0, 0, $urandom);
    chk("pre_clr_next", m_next, 32'h10);
    drive(1, 1, 1, 7'b0110011, 1, 2, 3, 0, 7'h20, 0);
    chk("clr_addr", out_addr, BASE);
    send(7'b0110011, 1, 2, 3, 0, 0);
    chk("after_clr_addr", out_addr, BASE + 4);
    drive(1, 0, 0, 7'b0010011, 1, 0, 0, 0, 0, 1);
    #2 rst_n = 0;
    #1 chk("async_rst_valid", {31'b0, out_valid}, 0);
    do_reset();
    for (int i = 0; i < 600; i++) begin
      ops[9] = 7'($urandom);
      case ($urandom_range(0, 11))
        0: sv = int'($urandom_range(0, 4095)) - 2048;
        1: sv = 2047;
        2: sv = 2048;
        3: sv = -2048;
        4: sv = -2049;
        5: sv = 4094;
        6: sv = -4096;
        7: sv = 4096;
        8: sv = 1048574;
        9: sv = -1048576;
        10: sv = 1048576;
        default: sv = int'($urandom);
      endcase
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
            ops[$urandom_range(0, 9)], 5'($urandom), 5'($urandom), 5'($urandom),
            3'($urandom), 7'($urandom), sv);
    end
    for (int i = 0; i < 260; i++) send(7'b1111111, 0, 0, 0, 0, 0);
    chk("err_sat", {24'b0, err_count}, 255);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
